instr_fetch: RTL and testbench

Instruction fetch and next-PC unit for the WISC multi-cycle core. It drives the 16-bit instruction word into the instruction decoder and reads back the decoder's control-flow outputs: `sawBranch`, `branchOp`, `sawJump` and `hlt`. From those outputs and the ALU flags it resolves the next PC, then fetches that instruction over a ready-handshake instruction-memory port. The unit holds one instruction in flight at a time.

---
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch / next-PC unit for the WISC multi-cycle core: one instruction in flight.
// Optional fetch timeout-and-reissue is enabled by defining IMEM_RETRY_EN.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_vld,
  input  logic        advance,
  input  logic        sawBranch,
  input  logic [2:0]  branchOp,
  input  logic        sawJump,
  input  logic        hlt,
  input  logic [15:0] jr_target,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_v,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        halted
);

  // JR opcode in instr[15:12]; any other jump with sawJump is JAL.
  localparam logic [3:0] OPC_JR = 4'hD;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
`ifdef IMEM_RETRY_EN
    , RETRY
`endif
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic        rd_q;
  logic        vld_q;
  logic        halted_q;
  logic        taken;
  logic [15:0] pc_d;

`ifdef IMEM_RETRY_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  logic [3:0] wait_q;
`endif

  always_comb begin
    taken = 1'b0;
    case (branchOp)
      3'b000:  taken = !flag_z;
      3'b001:  taken = flag_z;
      3'b010:  taken = !flag_z && !flag_n;
      3'b011:  taken = flag_n;
      3'b100:  taken = flag_z || !flag_n;
      3'b101:  taken = flag_n || flag_z;
      3'b110:  taken = flag_v;
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    pc_d = pc_q + 16'd1;
    if (sawJump && instr_q[15:12] == OPC_JR)
      pc_d = jr_target;
    else if (sawJump)
      pc_d = pc_q + 16'd1 + {{4{instr_q[11]}}, instr_q[11:0]};
    else if (sawBranch && taken)
      pc_d = pc_q + 16'd1 + {{7{instr_q[8]}}, instr_q[8:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      rd_q     <= 1'b0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
`ifdef IMEM_RETRY_EN
      wait_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          rd_q    <= 1'b1;
`ifdef IMEM_RETRY_EN
          wait_q  <= '0;
`endif
        end
        FETCH: begin
          if (imem_rdy) begin
            instr_q <= imem_data;
            vld_q   <= 1'b1;
            rd_q    <= 1'b0;
            state_q <= ISSUE;
          end
`ifdef IMEM_RETRY_EN
          // A ready arriving on the last counted cycle takes precedence over the retry.
          else if (wait_q == WAIT_LAST) begin
            rd_q    <= 1'b0;
            wait_q  <= '0;
            state_q <= RETRY;
          end else begin
            wait_q  <= wait_q + 4'd1;
          end
`endif
        end
        ISSUE: begin
          if (advance) begin
            vld_q <= 1'b0;
            if (hlt) begin
              halted_q <= 1'b1;
              state_q  <= HALT;
            end else begin
              pc_q    <= pc_d;
              rd_q    <= 1'b1;
              state_q <= FETCH;
`ifdef IMEM_RETRY_EN
              wait_q  <= '0;
`endif
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
`ifdef IMEM_RETRY_EN
        RETRY: begin
          rd_q    <= 1'b1;
          wait_q  <= '0;
          state_q <= FETCH;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_rd   = rd_q;
  assign instr     = instr_q;
  assign instr_vld = vld_q;
  assign pc        = pc_q;
  assign pc_plus1  = pc_q + 16'd1;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed next-PC table, timing sequences,
// and randomized instructions against a next-PC reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_vld;
  logic        advance;
  logic        sawBranch;
  logic [2:0]  branchOp;
  logic        sawJump;
  logic        hlt;
  logic [15:0] jr_target;
  logic        flag_z, flag_n, flag_v;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_vld(instr_vld), .advance(advance),
    .sawBranch(sawBranch), .branchOp(branchOp), .sawJump(sawJump), .hlt(hlt),
    .jr_target(jr_target), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .pc(pc), .pc_plus1(pc_plus1), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic bit cond_true(input logic [2:0] op, input bit z, input bit n, input bit v);
    case (op)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] cur, input logic [15:0] ins,
      input bit br, input logic [2:0] op, input bit jmp, input logic [15:0] jr,
      input bit z, input bit n, input bit v);
    int off;
    int nxt;
    if (jmp && ins[15:12] == 4'hD) return jr;
    off = 0;
    if (jmp) begin
      off = int'(ins[11:0]);
      if (off >= 2048) off -= 4096;
    end else if (br && cond_true(op, z, n, v)) begin
      off = int'(ins[8:0]);
      if (off >= 256) off -= 512;
    end
    nxt = ((int'(cur) + 1 + off) % 65536 + 65536) % 65536;
    return nxt[15:0];
  endfunction

  task automatic clear_dec();
    advance = 0; sawBranch = 0; branchOp = 0; sawJump = 0; hlt = 0;
    jr_target = 0; flag_z = 0; flag_n = 0; flag_v = 0;
  endtask

  // Holds ready low for 'waits' cycles (expecting a steady request), then returns data.
  task automatic do_fetch(input logic [15:0] data, input int waits, input logic [15:0] addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      imem_rdy = 0;
      check("wait_rd", {15'd0, imem_rd}, 16'd1);
      check("wait_addr", imem_addr, addr);
    end
    @(negedge clk);
    imem_rdy = 1; imem_data = data;
    @(posedge clk); #1;
    imem_rdy = 0;
    check("fetch_vld", {15'd0, instr_vld}, 16'd1);
    check("fetch_instr", instr, data);
  endtask

  task automatic do_retire(input bit br, input logic [2:0] op, input bit jmp, input bit h,
      input logic [15:0] jr, input bit z, input bit n, input bit v);
    @(negedge clk);
    advance = 1; sawBranch = br; branchOp = op; sawJump = jmp; hlt = h;
    jr_target = jr; flag_z = z; flag_n = n; flag_v = v;
    @(posedge clk); #1;
    clear_dec();
  endtask

  task automatic goto_pc(input logic [15:0] cur, input logic [15:0] target);
    do_fetch(16'hD000, 0, cur);
    do_retire(0, 0, 1, 0, target, 0, 0, 0);
    check("goto_pc", pc, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_pc", pc, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_ctrl", {13'd0, instr_vld, imem_rd, halted}, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    #1 check("idle_rd", {15'd0, imem_rd}, 16'd0);
    @(posedge clk); #1;
    check("first_rd", {15'd0, imem_rd}, 16'd1);
    check("first_addr", imem_addr, 16'h0000);
  endtask

  typedef struct {
    logic [15:0] start;
    logic [15:0] ins;
    bit          br;
    logic [2:0]  op;
    bit          jmp;
    logic [15:0] jr;
    bit          z, n, v;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[12];
  logic [15:0] mpc;

  initial begin
    rst_n = 0; imem_rdy = 0; imem_data = 0;
    clear_dec();

    vecs[0]  = '{16'h0010, 16'hC1FC, 1, 3'd1, 0, 16'h0, 1, 0, 0, 16'h000D};
    vecs[1]  = '{16'h0010, 16'hC1FC, 1, 3'd1, 0, 16'h0, 0, 0, 0, 16'h0011};
    vecs[2]  = '{16'h0020, 16'hE010, 0, 3'd0, 1, 16'h0, 0, 0, 0, 16'h0031};
    vecs[3]  = '{16'h1234, 16'hD000, 0, 3'd0, 1, 16'hBEEF, 0, 0, 0, 16'hBEEF};
    vecs[4]  = '{16'hFFFF, 16'h0000, 0, 3'd0, 0, 16'h0, 0, 0, 0, 16'h0000};
    vecs[5]  = '{16'h0001, 16'hC1FC, 1, 3'd7, 0, 16'h0, 0, 0, 0, 16'hFFFE};
    vecs[6]  = '{16'h0003, 16'hE800, 0, 3'd0, 1, 16'h0, 0, 0, 0, 16'hF804};
    vecs[7]  = '{16'h0100, 16'hC0FF, 1, 3'd2, 0, 16'h0, 0, 0, 0, 16'h0200};
    vecs[8]  = '{16'h0100, 16'hC0FF, 1, 3'd2, 0, 16'h0, 0, 1, 0, 16'h0101};
    vecs[9]  = '{16'h0050, 16'hC100, 1, 3'd6, 0, 16'h0, 0, 0, 1, 16'hFF51};
    vecs[10] = '{16'h0040, 16'hE005, 1, 3'd7, 1, 16'h0, 0, 0, 0, 16'h0046};
    vecs[11] = '{16'h0200, 16'hC010, 1, 3'd5, 0, 16'h0, 0, 0, 0, 16'h0201};

    repeat (2) @(posedge clk);
    do_reset();

    // Zero-wait fetch of 0x1123, then a plain retire.
    do_fetch(16'h1123, 0, 16'h0000);
    do_retire(0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pc1", pc, 16'h0001);
    check("seq_vld_drop", {15'd0, instr_vld}, 16'd0);
    mpc = 16'h0001;

    foreach (vecs[k]) begin
      goto_pc(mpc, vecs[k].start);
      do_fetch(vecs[k].ins, 0, vecs[k].start);
      check("tbl_pc_plus1", pc_plus1, vecs[k].start + 16'd1);
      do_retire(vecs[k].br, vecs[k].op, vecs[k].jmp, 0, vecs[k].jr,
                vecs[k].z, vecs[k].n, vecs[k].v);
      check("tbl_next_pc", pc, vecs[k].exp_pc);
      mpc = vecs[k].exp_pc;
    end

    // Delayed ready: request and address held stable for 4 cycles.
    do_fetch(16'h0000, 3, mpc);
    do_retire(0, 0, 0, 0, 0, 0, 0, 0);
    mpc = mpc + 16'd1;
    check("delay_pc", pc, mpc);

    // Reset asserted mid-wait.
    @(negedge clk); imem_rdy = 0;
    @(negedge clk);
    do_reset();
    mpc = 16'h0000;

    for (int i = 0; i < 200; i++) begin
      logic [15:0] ins;
      bit br, jmp, z, n, v;
      logic [2:0] op;
      logic [15:0] jr;
      logic [15:0] exp;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hD;
      br = 1'($urandom); jmp = ($urandom_range(0, 3) == 0);
      op = 3'($urandom); jr = 16'($urandom);
      z = 1'($urandom); n = 1'($urandom); v = 1'($urandom);
      exp = ref_next(mpc, ins, br, op, jmp, jr, z, n, v);
      do_fetch(ins, int'($urandom_range(0, 2)), mpc);
      check("rnd_pc_plus1", pc_plus1, mpc + 16'd1);
      do_retire(br, op, jmp, 0, jr, z, n, v);
      check("rnd_next_pc", pc, exp);
      mpc = exp;
    end

`ifdef IMEM_RETRY_EN
    // Withhold ready: 15 requesting cycles, one idle cycle, then reissue at same address.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("retry_rd_hi", {15'd0, imem_rd}, 16'd1);
    end
    @(negedge clk);
    check("retry_rd_lo", {15'd0, imem_rd}, 16'd0);
    @(negedge clk);
    check("retry_rd_again", {15'd0, imem_rd}, 16'd1);
    check("retry_addr", imem_addr, mpc);
    do_fetch(16'h0000, 0, mpc);
    do_retire(0, 0, 0, 0, 0, 0, 0, 0);
    mpc = mpc + 16'd1;
    // Ready on the 15th cycle wins over the retry.
    do_fetch(16'h4321, 14, mpc);
    do_retire(0, 0, 0, 0, 0, 0, 0, 0);
    mpc = mpc + 16'd1;
`endif

    // Halt at 0x0005; hlt outranks a simultaneous jump and branch.
    goto_pc(mpc, 16'h0005);
    do_fetch(16'hF000, 0, 16'h0005);
    do_retire(1, 3'd7, 1, 1, 16'h1111, 0, 0, 0);
    check("halt_flag", {15'd0, halted}, 16'd1);
    check("halt_pc", pc, 16'h0005);
    check("halt_vld", {15'd0, instr_vld}, 16'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      advance = ~advance; imem_rdy = 1;
      @(posedge clk); #1;
      check("halt_rd", {15'd0, imem_rd}, 16'd0);
      check("halt_hold_pc", pc, 16'h0005);
    end
    clear_dec(); imem_rdy = 0;
    do_reset();
    check("post_halt_clear", {15'd0, halted}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
